// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for control_sequencer and its sub-modules.
//   - seq_state_t : sequencer FSM states
//   - MDR_*       : mdr_read select encodings (bus / memory / immediate)
//   - DEST_*      : pre_dest register codes
//   - OPC_*_DEF   : default opcodes for the move-from-special-register ops
//   - WAIT_CNT_W  : width of the fetch wait counter
package seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PRE_A,
      ST_PRE_B,
      ST_T0,
      ST_T1,
      ST_T1W,
      ST_T2,
      ST_T3,
      ST_FAULT
   } seq_state_t;

   localparam logic [1:0] MDR_BUS = 2'b00;
   localparam logic [1:0] MDR_MEM = 2'b01;
   localparam logic [1:0] MDR_IMM = 2'b10;

   localparam logic [1:0] DEST_LO = 2'd0;
   localparam logic [1:0] DEST_PC = 2'd1;
   localparam logic [1:0] DEST_HI = 2'd2;
   localparam logic [1:0] DEST_Y  = 2'd3;

   localparam logic [4:0] OPC_MFHI_DEF = 5'd16;
   localparam logic [4:0] OPC_MFLO_DEF = 5'd17;

   localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: saturating wait-state counter with terminal count.
// Ports:
//   clk   in  clock
//   reset in  asynchronous active-low reset
//   clr   in  synchronous clear (priority over en)
//   en    in  count enable
//   tc    out high when the count after this cycle's increment reaches LIMIT
module seq_wait_timer
   import seq_pkg::*;
#(
   parameter int unsigned LIMIT = 15
)(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [WAIT_CNT_W:0] LIMIT_V = LIMIT[WAIT_CNT_W:0];

   logic [WAIT_CNT_W-1:0] count;
   logic [WAIT_CNT_W:0]   count_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != '1))
         count <= count + 1'b1;
   end

   // Compare the post-increment value so the LIMIT-th enabled cycle is terminal.
   assign count_inc = {1'b0, count} + 1'b1;
   assign tc        = (count_inc >= LIMIT_V);

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: FSM driving the single-bus datapath strobes through
// register preload (PRE_A/PRE_B), fetch (T0..T2, T1W wait states) and a
// move-from-HI/LO execute step (T3).
// Optional feature macro: SEQ_TIMEOUT_EN -- fetch wait timeout into FAULT.
// Ports:
//   clk, reset (async active-low)
//   start, cont                 run control (level start; cont loops T3->T0)
//   pre_valid/pre_ready         preload handshake, pre_data/pre_dest payload
//   mem_ready, ir_val           memory data valid, current IR
//   Immediate, mdr_read         MDR mux data/select
//   *out / *in / IncPc/read/GRA datapath strobes
//   busy, fault, illegal        status; instr_count completed T3 count
module control_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned WAIT_LIMIT = 15,
   parameter logic [4:0]  OPC_MFHI   = OPC_MFHI_DEF,
   parameter logic [4:0]  OPC_MFLO   = OPC_MFLO_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cont,
   input  logic              pre_valid,
   output logic              pre_ready,
   input  logic [DATA_W-1:0] pre_data,
   input  logic [1:0]        pre_dest,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] ir_val,
   output logic [DATA_W-1:0] Immediate,
   output logic [1:0]        mdr_read,
   output logic              PCout,
   output logic              Zlowout,
   output logic              MDRout,
   output logic              HIout,
   output logic              LOout,
   output logic              MARin,
   output logic              Zlowin,
   output logic              PCin,
   output logic              MDRin,
   output logic              IRin,
   output logic              LOin,
   output logic              HIin,
   output logic              Yin,
   output logic              Rin,
   output logic              IncPc,
   output logic              read,
   output logic              GRA,
   output logic              busy,
   output logic              fault,
   output logic              illegal,
   output logic [15:0]       instr_count
);

   seq_state_t        state, state_nxt;
   logic [DATA_W-1:0] pre_data_q;
   logic [1:0]        pre_dest_q;
   logic [4:0]        opcode;
   logic              unused_bits;

   assign opcode = ir_val[DATA_W-1 -: 5];

`ifdef SEQ_TIMEOUT_EN
   logic wait_tc;

   seq_wait_timer #(
      .LIMIT (WAIT_LIMIT)
   ) u_wait_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (state == ST_T1),
      .en    (state == ST_T1W),
      .tc    (wait_tc)
   );

   assign fault       = (state == ST_FAULT);
   assign unused_bits = ^ir_val[DATA_W-6:0];
`else
   assign fault       = 1'b0;
   assign unused_bits = ^{ir_val[DATA_W-6:0], WAIT_LIMIT};
`endif

   // ---------------- state and data registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pre_data_q  <= '0;
         pre_dest_q  <= '0;
         instr_count <= '0;
      end else begin
         state <= state_nxt;
         if ((state == ST_IDLE) && pre_valid) begin
            pre_data_q <= pre_data;
            pre_dest_q <= pre_dest;
         end
         if (state == ST_T3)
            instr_count <= instr_count + 16'd1;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (pre_valid)
               state_nxt = ST_PRE_A;
            else if (start)
               state_nxt = ST_T0;
         end
         ST_PRE_A: state_nxt = ST_PRE_B;
         ST_PRE_B: state_nxt = ST_IDLE;
         ST_T0:    state_nxt = ST_T1;
         ST_T1:    state_nxt = mem_ready ? ST_T2 : ST_T1W;
         ST_T1W: begin
            if (mem_ready)
               state_nxt = ST_T2;
`ifdef SEQ_TIMEOUT_EN
            else if (wait_tc)
               state_nxt = ST_FAULT;
`endif
         end
         ST_T2:    state_nxt = ST_T3;
         ST_T3:    state_nxt = cont ? ST_T0 : ST_IDLE;
         ST_FAULT: state_nxt = ST_FAULT;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- output decode ----------------
   // pre_ready is gated by reset so every output is low while reset is held.
   assign pre_ready = reset && (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign Immediate = pre_data_q;

   always_comb begin
      mdr_read = MDR_BUS;
      PCout    = 1'b0;
      Zlowout  = 1'b0;
      MDRout   = 1'b0;
      HIout    = 1'b0;
      LOout    = 1'b0;
      MARin    = 1'b0;
      Zlowin   = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      LOin     = 1'b0;
      HIin     = 1'b0;
      Yin      = 1'b0;
      Rin      = 1'b0;
      IncPc    = 1'b0;
      read     = 1'b0;
      GRA      = 1'b0;
      illegal  = 1'b0;
      case (state)
         ST_PRE_A: begin
            mdr_read = MDR_IMM;
            MDRin    = 1'b1;
         end
         ST_PRE_B: begin
            MDRout = 1'b1;
            case (pre_dest_q)
               DEST_LO: LOin = 1'b1;
               DEST_PC: PCin = 1'b1;
               DEST_HI: HIin = 1'b1;
               DEST_Y:  Yin  = 1'b1;
               default: ;
            endcase
         end
         ST_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPc  = 1'b1;
            Zlowin = 1'b1;
         end
         ST_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            read    = 1'b1;
            if (mem_ready) begin
               MDRin    = 1'b1;
               mdr_read = MDR_MEM;
            end
         end
         ST_T1W: begin
            read = 1'b1;
            if (mem_ready) begin
               MDRin    = 1'b1;
               mdr_read = MDR_MEM;
            end
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            if (opcode == OPC_MFLO) begin
               GRA   = 1'b1;
               Rin   = 1'b1;
               LOout = 1'b1;
            end else if (opcode == OPC_MFHI) begin
               GRA   = 1'b1;
               Rin   = 1'b1;
               HIout = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
